// File: rtl/mul_bist_sweep.sv
// Self-test sweep engine for a combinational WIDTHxWIDTH multiplier: drives every
// operand pair, compares the returned product to an internal golden product, and reports results.
module mul_bist_sweep #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int IW   = 2 * WIDTH;
  localparam int PH_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, idx_nxt;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fev_q, fev_d;
  logic [WIDTH-1:0]   fea_q, fea_d, feb_q, feb_d;
  logic [IW-1:0]      golden;

  assign golden  = IW'(mul_a_q) * IW'(mul_b_q);
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    feb_d   = feb_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          phase_d = '0;
          mul_a_d = '0;
          mul_b_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          feb_d   = '0;
        end
      end
      RUN: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (mul_p != golden) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fea_d = mul_a_q;
              feb_d = mul_b_q;
            end
          end
          if (idx_q == '1) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
            mul_a_d = '0;
            mul_b_d = '0;
          end else begin
            // Operands are loaded together with idx so mul_a/mul_b always mirror it.
            idx_d   = idx_nxt;
            mul_a_d = idx_nxt[WIDTH-1:0];
            mul_b_d = idx_nxt[IW-1:WIDTH];
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      phase_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      feb_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      feb_q   <= feb_d;
    end
  end

  assign mul_a           = mul_a_q;
  assign mul_b           = mul_b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_a     = fea_q;
  assign first_err_b     = feb_q;

endmodule
